// File: rtl/crypto_job_arbiter.sv
// crypto_job_arbiter: round-robin sharing of one crypto core between a CPU (port 0) and a DMA (port 1) requester,
// with a watchdog-bounded wait for the core's FIN strobe and a valid/ready result return.
module crypto_job_arbiter #(
  parameter int DATA_W  = 16,
  parameter int KEY_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [3:0]          req_mode,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*KEY_W-1:0]  req_key,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [KEY_W-1:0]    resp_key,
  output logic                resp_err,
  output logic                core_bgn,
  output logic [1:0]          core_mode,
  output logic [DATA_W-1:0]   core_data,
  output logic [KEY_W-1:0]    core_key,
  input  logic                core_done,
  input  logic [DATA_W-1:0]   core_data_out,
  input  logic [KEY_W-1:0]    core_key_out,
  output logic                busy
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, RESP} state_e;

  state_e            state_q;
  logic              rr_q, owner_q, win_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        req_ready_q, resp_valid_q, core_mode_q;
  logic [DATA_W-1:0] resp_data_q, core_data_q;
  logic [KEY_W-1:0]  resp_key_q, core_key_q;
  logic              resp_err_q, core_bgn_q, busy_q;

  // Contention goes to the round-robin pointer; a lone requester always wins.
  assign win_d = (&req_valid) ? rr_q : req_valid[1];
  assign wd_d  = wd_q + WD_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      wd_q         <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_key_q   <= '0;
      resp_err_q   <= 1'b0;
      core_bgn_q   <= 1'b0;
      core_mode_q  <= '0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid) begin
          owner_q     <= win_d;
          req_ready_q <= {win_d, ~win_d};
          core_mode_q <= win_d ? req_mode[3:2] : req_mode[1:0];
          core_data_q <= win_d ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
          core_key_q  <= win_d ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
          busy_q      <= 1'b1;
          state_q     <= LOAD;
        end
        LOAD: begin
          req_ready_q <= '0;
          wd_q        <= '0;
          // Only 01 (encrypt) and 10 (decrypt) are legal; anything else is refused without touching the core.
          if (^core_mode_q) begin
            core_bgn_q <= 1'b1;
            state_q    <= START;
          end else begin
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            resp_key_q   <= '0;
            resp_valid_q <= {owner_q, ~owner_q};
            state_q      <= RESP;
          end
        end
        START: begin
          core_bgn_q <= 1'b0;
          wd_q       <= '0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          wd_q <= wd_d;
          if (core_done) begin
            resp_err_q   <= 1'b0;
            resp_data_q  <= core_data_out;
            resp_key_q   <= core_key_out;
            resp_valid_q <= {owner_q, ~owner_q};
            state_q      <= RESP;
          end else if (wd_d == WD_W'(TIMEOUT)) begin
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            resp_key_q   <= '0;
            resp_valid_q <= {owner_q, ~owner_q};
            state_q      <= RESP;
          end
        end
        RESP: if (resp_ready[owner_q]) begin
          resp_valid_q <= '0;
          rr_q         <= ~owner_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_key   = resp_key_q;
  assign resp_err   = resp_err_q;
  assign core_bgn   = core_bgn_q;
  assign core_mode  = core_mode_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_crypto_job_arbiter.sv
// tb_crypto_job_arbiter: directed jobs with a behavioural core; responses are checked by a monitor
// against an expectation queue filled by the stimulus.
module tb_crypto_job_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_mode;
  logic [31:0] req_data;
  logic [31:0] req_key;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_data, resp_key;
  logic        resp_err;
  logic        core_bgn;
  logic [1:0]  core_mode;
  logic [15:0] core_data, core_key;
  logic        core_done;
  logic [15:0] core_data_out, core_key_out;
  logic        busy;

  crypto_job_arbiter #(.DATA_W(16), .KEY_W(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data), .req_key(req_key),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_key(resp_key), .resp_err(resp_err),
    .core_bgn(core_bgn), .core_mode(core_mode), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_data_out(core_data_out), .core_key_out(core_key_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  port;
    logic [15:0] d;
    logic [15:0] k;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   lat = 0, hold = 0, bgn_cnt = 0;
  logic [15:0] xmask = '0, kmask = '0;
  logic force_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Core model: result = operand ^ mask, delivered lat cycles after the begin pulse; lat=0 never finishes.
  initial begin
    int cnt = 0;
    core_done = 1'b0;
    core_data_out = '0;
    core_key_out = '0;
    forever begin
      @(negedge clk);
      core_done = force_done;
      if (!rst) cnt = 0;
      else if (core_bgn) begin
        cnt = lat;
        bgn_cnt++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_data_out = core_data ^ xmask;
          core_key_out = core_key ^ kmask;
        end
      end
    end
  end

  // Consumer: withholds ready for hold cycles, meanwhile asserting only the non-owner's ready.
  initial begin
    int wcnt = 0;
    resp_ready = '0;
    forever begin
      @(negedge clk);
      if (resp_valid == 2'b00) begin
        wcnt = 0;
        resp_ready = '0;
      end else begin
        resp_ready = (wcnt >= hold) ? resp_valid : ~resp_valid;
        wcnt++;
      end
    end
  end

  // Monitor: compare each new response against the queue head, then check it stays stable.
  initial begin
    bit seen = 0;
    logic [34:0] snap = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid != 2'b00 && !seen) begin
        seen = 1;
        snap = {resp_valid, resp_data, resp_key, resp_err};
        if (q.size() == 0) chk("unexpected_resp", resp_valid, 0);
        else begin
          e = q.pop_front();
          chk("resp_port", resp_valid, e.port);
          chk("resp_data", resp_data, e.d);
          chk("resp_key", resp_key, e.k);
          chk("resp_err", resp_err, e.e);
        end
      end else if (resp_valid != 2'b00) chk("resp_stable", {resp_valid, resp_data, resp_key, resp_err}, snap);
      else seen = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic logic any_out();
    return |{req_ready, resp_valid, resp_data, resp_key, resp_err, core_bgn, core_mode, core_data, core_key, busy};
  endfunction

  task automatic set_req(input int p, input logic [1:0] m, input logic [15:0] d, input logic [15:0] k);
    req_mode[p*2 +: 2] = m;
    req_data[p*16 +: 16] = d;
    req_key[p*16 +: 16] = k;
    req_valid[p] = 1'b1;
  endtask

  // Waits for the grant, drops the request, and reports req_ready/resp_valid one cycle later.
  task automatic get_grant(input int p, output logic [1:0] rr_n, output logic [1:0] rv_n);
    int n = 0;
    while (!req_ready[p] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[p]) chk("grant_timeout", req_ready[p], 1);
    req_valid[p] = 1'b0;
    @(negedge clk);
    rr_n = req_ready;
    rv_n = resp_valid;
  endtask

  task automatic wait_bgn();
    int n = 0;
    while (!core_bgn && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!core_bgn) chk("bgn_timeout", core_bgn, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] rr_n, rv_n;
    int b0, c;
    rst = 1'b0;
    req_valid = '0;
    req_mode = '0;
    req_data = '0;
    req_key = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single CPU job, 40-cycle core
    xmask = 16'h486E; kmask = 16'h0000; lat = 40;
    b0 = bgn_cnt;
    q.push_back('{2'b01, 16'h5A5A, 16'hABCD, 1'b0});
    set_req(0, 2'b01, 16'h1234, 16'hABCD);
    get_grant(0, rr_n, rv_n);
    chk("t1_ready_one_cycle", rr_n, 2'b00);
    wait_bgn();
    chk("t1_core_mode", core_mode, 2'b01);
    chk("t1_core_data", core_data, 16'h1234);
    chk("t1_core_key", core_key, 16'hABCD);
    drain();
    chk("t1_bgn_pulses", bgn_cnt - b0, 1);

    // Contention: grants alternate 0,1,0,1 from a fresh pointer
    do_reset();
    xmask = 16'hFFFF; kmask = 16'hFFFF; lat = 3;
    for (int g = 0; g < 4; g++)
      q.push_back(g[0] ? '{2'b10, 16'hDDDD, 16'hC3C3, 1'b0} : '{2'b01, 16'hEEEE, 16'hF0F0, 1'b0});
    req_mode = 4'b0101; req_data = 32'h2222_1111; req_key = 32'h3C3C_0F0F;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      c = 0;
      while (req_ready == 2'b00 && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("t2_grant_order", req_ready, g[0] ? 2'b10 : 2'b01);
      if (g == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    drain();

    // Invalid mode: refused in LOAD, no core start
    b0 = bgn_cnt;
    q.push_back('{2'b01, 16'h0000, 16'h0000, 1'b1});
    set_req(0, 2'b11, 16'hBEEF, 16'hCAFE);
    get_grant(0, rr_n, rv_n);
    chk("t3_ready_one_cycle", rr_n, 2'b00);
    chk("t3_resp_after_load", rv_n, 2'b01);
    drain();
    chk("t3_no_bgn", bgn_cnt - b0, 0);

    // Watchdog: core silent, 255 cycles in WAIT_DONE
    xmask = '0; kmask = '0; lat = 0; hold = 3;
    q.push_back('{2'b01, 16'h0000, 16'h0000, 1'b1});
    set_req(0, 2'b01, 16'h0F0F, 16'h7070);
    get_grant(0, rr_n, rv_n);
    wait_bgn();
    c = 0;
    while (resp_valid == 2'b00 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("t4_timeout_cycles", c, 256);
    chk("t4_busy_in_resp", busy, 1);
    c = 0;
    while (resp_valid != 2'b00 && c < 20) begin
      chk("t4_busy_until_ready", busy, 1);
      @(negedge clk);
      c++;
    end
    chk("t4_busy_after", busy, 0);
    hold = 0;
    drain();

    // Reset mid-job drops it; a stray done afterwards is ignored
    lat = 100;
    set_req(1, 2'b01, 16'h5555, 16'h6666);
    get_grant(1, rr_n, rv_n);
    wait_bgn();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("t5_async_reset_outputs", any_out(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_stray_done_ignored", {busy, resp_valid}, 3'b000);
    lat = 4; xmask = 16'h00FF; kmask = 16'hFF00;
    q.push_back('{2'b01, 16'h01DC, 16'hFB56, 1'b0});
    set_req(0, 2'b10, 16'h0123, 16'h0456);
    get_grant(0, rr_n, rv_n);
    drain();

    // Held response: stable outputs, other port waits for the handshake
    xmask = '0; kmask = '0; lat = 5; hold = 10;
    q.push_back('{2'b01, 16'h0042, 16'h0099, 1'b0});
    q.push_back('{2'b10, 16'h7777, 16'h1111, 1'b0});
    set_req(0, 2'b01, 16'h0042, 16'h0099);
    get_grant(0, rr_n, rv_n);
    c = 0;
    while (resp_valid == 2'b00 && c < 50) begin
      @(negedge clk);
      c++;
    end
    set_req(1, 2'b01, 16'h7777, 16'h1111);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t6_no_grant_in_resp", {req_ready, resp_valid}, 4'b0001);
    end
    get_grant(1, rr_n, rv_n);
    hold = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
